// File: rtl/instruction_fetch.sv
// Fetch stage: holds the fetch PC, drives the ROM word address, buffers
// returned words in a small prefetch FIFO and hands {instr, pc} to decode
// over a valid/ready handshake. Execute can redirect the PC and flush.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    output logic [9:0]  rom_address_o,
    input  logic [31:0] rom_data_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o,
    output logic        fetch_fault_o
);

    localparam int unsigned    AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned    CW      = AW + 1;
    localparam logic [CW-1:0]  DEPTH_C = CW'(DEPTH);
    localparam logic [31:0]    NOP     = 32'h0000_0013;

    logic [31:0]   f_pc_q,   f_pc_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q,  count_d;
    logic          fault_q,  fault_d;

    // FIFO storage; contents are only observable while count is non-zero,
    // so it needs no reset.
    logic [31:0] mem_instr_q [DEPTH];
    logic [31:0] mem_pc_q    [DEPTH];

    logic pop;
    logic push;
    logic misaligned;

    // The ROM is addressed straight from the PC register; fetch wraps at 4 KiB.
    assign rom_address_o = f_pc_q[11:2];
    assign fetch_fault_o = fault_q;

    // Head outputs come only from registers, so they are stable all cycle
    // and fall back to NOP/0 as soon as the FIFO is emptied or reset.
    assign instr_valid_o = (count_q != '0);
    assign instr_o       = instr_valid_o ? mem_instr_q[rd_ptr_q] : NOP;
    assign instr_pc_o    = instr_valid_o ? mem_pc_q[rd_ptr_q]    : 32'h0;

    assign pop        = instr_valid_o & instr_ready_i;
    assign misaligned = redirect_i & (redirect_pc_i[1:0] != 2'b00);
    // A pop frees a slot in the same cycle, so a full FIFO still streams.
    assign push       = !redirect_i && !fault_q && ((count_q < DEPTH_C) || pop);

    // Next-state logic: redirect flushes everything and overrides push/pop.
    always_comb begin
        f_pc_d   = f_pc_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        fault_d  = fault_q;
        if (redirect_i) begin
            f_pc_d   = redirect_pc_i;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
            fault_d  = fault_q | misaligned;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
                f_pc_d   = f_pc_q + 32'd4;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control state register with asynchronous active-low reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            f_pc_q   <= RESET_PC;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            fault_q  <= 1'b0;
        end else begin
            f_pc_q   <= f_pc_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            fault_q  <= fault_d;
        end
    end

    // Capture the combinational ROM word together with the PC it came from.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_instr_q[wr_ptr_q] <= rom_data_i;
            mem_pc_q[wr_ptr_q]    <= f_pc_q;
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed timing checks plus a randomized
// phase, with accepted instructions checked by a scoreboard monitor.
module tb_instruction_fetch;

    logic        clk;
    logic        rst_n;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        ready;

    logic [9:0]  rom_addr0, rom_addr1;
    logic [31:0] rom_data0, rom_data1;
    logic        valid0, valid1;
    logic [31:0] instr0, instr1, ipc0, ipc1;
    logic        fault0, fault1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } txn_t;
    txn_t exp_q[$];

    // ROM model: each word holds 0x1000_0000 + its word address.
    assign rom_data0 = 32'h1000_0000 + {22'b0, rom_addr0};
    assign rom_data1 = 32'h1000_0000 + {22'b0, rom_addr1};

    instruction_fetch #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut0 (
        .clk_i(clk), .rst_ni(rst_n),
        .rom_address_o(rom_addr0), .rom_data_i(rom_data0),
        .redirect_i(redirect), .redirect_pc_i(redirect_pc),
        .instr_valid_o(valid0), .instr_ready_i(ready),
        .instr_o(instr0), .instr_pc_o(ipc0), .fetch_fault_o(fault0)
    );

    instruction_fetch #(.RESET_PC(32'h0000_0100), .DEPTH(2)) dut1 (
        .clk_i(clk), .rst_ni(rst_n),
        .rom_address_o(rom_addr1), .rom_data_i(rom_data1),
        .redirect_i(redirect), .redirect_pc_i(redirect_pc),
        .instr_valid_o(valid1), .instr_ready_i(ready),
        .instr_o(instr1), .instr_pc_o(ipc1), .fetch_fault_o(fault1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [31:0] pc);
        return 32'h1000_0000 + ((pc >> 2) & 32'h3FF);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected stream after a reset or aligned redirect: consecutive words.
    task automatic seg_start(input logic [31:0] pc);
        exp_q.delete();
        for (int i = 0; i < 512; i++) begin
            txn_t t;
            t.pc    = pc + 32'(4 * i);
            t.instr = rom_word(t.pc);
            exp_q.push_back(t);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: mid-cycle, compare every accepted head against the scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            if (valid0 && ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL accept: unexpected pc %h instr %h at %0t", ipc0, instr0, $time);
                end else begin
                    txn_t t;
                    t = exp_q.pop_front();
                    chk("accept_pc", ipc0, t.pc);
                    chk("accept_instr", instr0, t.instr);
                    $display("accept pc=%h instr=%h", ipc0, instr0);
                end
            end else if (!valid0) begin
                chk("idle_instr", instr0, 32'h0000_0013);
                chk("idle_pc", ipc0, 32'h0);
            end
        end
    end

    initial begin
        logic        pend;
        logic [31:0] pend_pc;
        logic        pv, pr, prd;

        rst_n = 1'b1; ready = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_valid", {31'b0, valid0}, 32'd0);
        chk("rst_instr", instr0, 32'h0000_0013);
        chk("rst_pc", ipc0, 32'h0);
        chk("rst_addr", {22'b0, rom_addr0}, 32'd0);
        chk("rst_fault", {31'b0, fault0}, 32'd0);
        chk("rst_addr1", {22'b0, rom_addr1}, 32'd64);
        seg_start(32'h0);

        // Stream from reset.
        @(negedge clk);
        rst_n = 1'b1; ready = 1'b1;
        #1;
        chk("cyc0_valid", {31'b0, valid0}, 32'd0);
        step();
        chk("cyc1_valid", {31'b0, valid0}, 32'd1);
        chk("cyc1_pc", ipc0, 32'h0);
        chk("cyc1_instr", instr0, 32'h1000_0000);
        for (int i = 1; i < 5; i++) begin
            step();
            chk("stream_pc", ipc0, 32'(4 * i));
            chk("stream_instr", instr0, 32'h1000_0000 + 32'(i));
        end

        // Backpressure at PC 0x10.
        ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_valid", {31'b0, valid0}, 32'd1);
            chk("bp_pc", ipc0, 32'h10);
            chk("bp_instr", instr0, 32'h1000_0004);
            chk("bp_addr", {22'b0, rom_addr0}, 32'd6);
        end
        ready = 1'b1;
        step();
        chk("rel_pc1", ipc0, 32'h14);
        chk("rel_valid1", {31'b0, valid0}, 32'd1);
        step();
        chk("rel_pc2", ipc0, 32'h18);
        chk("rel_valid2", {31'b0, valid0}, 32'd1);

        // Redirect to 0x40 with a full FIFO.
        ready = 1'b0;
        step();
        step();
        redirect = 1'b1; redirect_pc = 32'h40;
        step();
        redirect = 1'b0;
        seg_start(32'h40);
        chk("redir_valid0", {31'b0, valid0}, 32'd0);
        chk("redir_addr", {22'b0, rom_addr0}, 32'd16);
        ready = 1'b1;
        step();
        chk("redir_valid1", {31'b0, valid0}, 32'd1);
        chk("redir_pc", ipc0, 32'h40);
        chk("redir_instr", instr0, 32'h1000_0010);

        // Wrap at 4 KiB.
        redirect = 1'b1; redirect_pc = 32'hFF8;
        step();
        redirect = 1'b0;
        seg_start(32'hFF8);
        chk("wrap_addr0", {22'b0, rom_addr0}, 32'd1022);
        step();
        chk("wrap_addr1", {22'b0, rom_addr0}, 32'd1023);
        chk("wrap_pc0", ipc0, 32'hFF8);
        chk("wrap_instr0", instr0, 32'h1000_03FE);
        step();
        chk("wrap_addr2", {22'b0, rom_addr0}, 32'd0);
        chk("wrap_pc1", ipc0, 32'hFFC);
        chk("wrap_instr1", instr0, 32'h1000_03FF);
        step();
        chk("wrap_pc2", ipc0, 32'h1000);
        chk("wrap_instr2", instr0, 32'h1000_0000);

        // Misaligned redirect sets a sticky fault.
        redirect = 1'b1; redirect_pc = 32'h42;
        step();
        redirect = 1'b0;
        exp_q.delete();
        chk("mis_fault", {31'b0, fault0}, 32'd1);
        chk("mis_valid", {31'b0, valid0}, 32'd0);
        step();
        step();
        chk("mis_valid_hold", {31'b0, valid0}, 32'd0);
        redirect = 1'b1; redirect_pc = 32'h0;
        step();
        redirect = 1'b0;
        step();
        step();
        chk("mis_fault_sticky", {31'b0, fault0}, 32'd1);
        chk("mis_valid_sticky", {31'b0, valid0}, 32'd0);

        // Reset pulse clears the fault.
        #2 rst_n = 1'b0;
        #1;
        chk("clr_fault", {31'b0, fault0}, 32'd0);
        seg_start(32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        step();
        chk("clr_valid", {31'b0, valid0}, 32'd1);
        chk("clr_pc", ipc0, 32'h4);

        // Randomized traffic with aligned redirects.
        pend = 1'b0; pend_pc = 32'h0;
        pv = valid0; pr = ready; prd = 1'b0;
        for (int c = 0; c < 400; c++) begin
            step();
            if (pend) begin
                seg_start(pend_pc);
                pend = 1'b0;
            end
            if (pv && pr && !prd)
                chk("thru_valid", {31'b0, valid0}, 32'd1);
            pv = valid0;
            ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) begin
                redirect = 1'b1;
                redirect_pc = $urandom() & 32'hFFFF_FFFC;
                pend = 1'b1;
                pend_pc = redirect_pc;
            end else begin
                redirect = 1'b0;
            end
            pr = ready;
            prd = redirect;
        end
        step();
        redirect = 1'b0;
        ready = 1'b1;
        if (pend) seg_start(pend_pc);
        step();
        step();

        // Mid-stream asynchronous reset, between clock edges.
        #2 rst_n = 1'b0;
        #1;
        chk("mrst_valid0", {31'b0, valid0}, 32'd0);
        chk("mrst_instr0", instr0, 32'h0000_0013);
        chk("mrst_addr0", {22'b0, rom_addr0}, 32'd0);
        chk("mrst_valid1", {31'b0, valid1}, 32'd0);
        chk("mrst_instr1", instr1, 32'h0000_0013);
        chk("mrst_addr1", {22'b0, rom_addr1}, 32'd64);
        seg_start(32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("mrst_rel_valid1", {31'b0, valid1}, 32'd1);
        chk("mrst_rel_pc1", ipc1, 32'h100);
        chk("mrst_rel_instr1", instr1, 32'h1000_0040);
        chk("mrst_rel_pc0", ipc0, 32'h0);
        step();
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
